// File: rtl/rc_mesh_sub_if.sv
// ---------------------------------------------------------------------------
// rc_mesh_sub_if : flit stream bundle between the input port and the crossbar
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rc_mesh_sub_if #(
  parameter int DATASIZE = 40
);
  logic [DATASIZE-1:0] data_in;
  logic                valid_in;
  logic                ready_out;
  logic [DATASIZE-1:0] data_out;
  logic [3:0]          direction_out;
  logic                valid_out;
  logic                rc_ready;

  modport slave (
    input  data_in, valid_in, rc_ready,
    output ready_out, data_out, direction_out, valid_out
  );

  modport master (
    output data_in, valid_in, rc_ready,
    input  ready_out, data_out, direction_out, valid_out
  );
endinterface

`default_nettype wire

// File: rtl/rc_mesh_sub.sv
// ---------------------------------------------------------------------------
// rc_mesh_sub : parametrised XY / minimal-adaptive route compute with skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rc_mesh_sub #(
  parameter int DATASIZE = 40,
  parameter int DST_LSB  = 32,
  parameter int X_NUM    = 3,
  parameter int Y_NUM    = 3,
  parameter int X_POS    = 0,
  parameter int Y_POS    = 0,
  parameter int WIDTH    = 3,
  parameter int ADAPTIVE = 1
) (
  input  logic             rc_clk,
  input  logic             rst_n,
  rc_mesh_sub_if.slave     bus,
  input  logic [WIDTH:0]   E_pressure_in,
  input  logic [WIDTH:0]   S_pressure_in,
  input  logic [WIDTH:0]   W_pressure_in,
  input  logic [WIDTH:0]   N_pressure_in,
  output logic [7:0]       bad_dst_cnt
);

  localparam logic [2:0] X_LIM  = 3'(X_NUM);
  localparam logic [2:0] Y_LIM  = 3'(Y_NUM);
  localparam logic [1:0] X_HERE = 2'(X_POS);
  localparam logic [1:0] Y_HERE = 2'(Y_POS);

  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] DIR_S    = 4'b0001;
  localparam logic [3:0] DIR_E    = 4'b0010;
  localparam logic [3:0] DIR_W    = 4'b0100;
  localparam logic [3:0] DIR_N    = 4'b1000;
  localparam logic [3:0] DIR_IDLE = 4'b1111;

  logic [3:0]          dst;
  logic [1:0]          dst_x;
  logic [1:0]          dst_y;
  logic                dst_bad;
  logic                go_e;
  logic                go_s;
  logic [3:0]          x_port;
  logic [3:0]          y_port;
  logic [WIDTH:0]      x_press;
  logic [WIDTH:0]      y_press;
  logic [3:0]          route;
  logic                tie_hit;
  logic                accept;
  logic                push;
  logic                main_free;

  logic                main_valid_q, main_valid_d;
  logic [DATASIZE-1:0] main_data_q,  main_data_d;
  logic [3:0]          main_dir_q,   main_dir_d;
  logic                skid_valid_q, skid_valid_d;
  logic [DATASIZE-1:0] skid_data_q,  skid_data_d;
  logic [3:0]          skid_dir_q,   skid_dir_d;
  logic                tie_q,        tie_d;
  logic [7:0]          bad_cnt_q,    bad_cnt_d;

  always_comb begin
    dst     = bus.data_in[DST_LSB +: 4];
    dst_x   = dst[1:0];
    dst_y   = dst[3:2];
    dst_bad = ({1'b0, dst_x} >= X_LIM) || ({1'b0, dst_y} >= Y_LIM);
    go_e    = dst_x > X_HERE;
    go_s    = dst_y > Y_HERE;

    x_port  = DIR_NONE;
    x_press = W_pressure_in;
    if (go_e) begin
      x_port  = DIR_E;
      x_press = E_pressure_in;
    end else if (dst_x != X_HERE) begin
      x_port  = DIR_W;
    end

    y_port  = DIR_NONE;
    y_press = N_pressure_in;
    if (go_s) begin
      y_port  = DIR_S;
      y_press = S_pressure_in;
    end else if (dst_y != Y_HERE) begin
      y_port  = DIR_N;
    end

    // With two productive ports the less loaded neighbour wins; ties alternate.
    route   = x_port | y_port;
    tie_hit = 1'b0;
    if (x_port != DIR_NONE && y_port != DIR_NONE) begin
      if (ADAPTIVE == 0) begin
        route = x_port;
      end else if (x_press < y_press) begin
        route = x_port;
      end else if (y_press < x_press) begin
        route = y_port;
      end else begin
        route   = tie_q ? y_port : x_port;
        tie_hit = 1'b1;
      end
    end
  end

  assign accept    = bus.valid_in && !skid_valid_q;
  assign push      = accept && !dst_bad;
  assign main_free = !main_valid_q || bus.rc_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_dir_d   = main_dir_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_dir_d   = skid_dir_q;
    tie_d        = tie_q;
    bad_cnt_d    = bad_cnt_q;

    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_dir_d   = skid_dir_q;
        skid_valid_d = push;
        if (push) begin
          skid_data_d = bus.data_in;
          skid_dir_d  = route;
        end
      end else if (push) begin
        main_valid_d = 1'b1;
        main_data_d  = bus.data_in;
        main_dir_d   = route;
      end else begin
        main_valid_d = 1'b0;
        main_dir_d   = DIR_IDLE;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = bus.data_in;
      skid_dir_d   = route;
    end

    if (push && tie_hit) begin
      tie_d = !tie_q;
    end
    if (accept && dst_bad && bad_cnt_q != 8'hFF) begin
      bad_cnt_d = bad_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_dir_q   <= DIR_IDLE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_dir_q   <= DIR_IDLE;
      tie_q        <= 1'b0;
      bad_cnt_q    <= 8'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_dir_q   <= main_dir_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_dir_q   <= skid_dir_d;
      tie_q        <= tie_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign bus.ready_out     = !skid_valid_q;
  assign bus.data_out      = main_data_q;
  assign bus.direction_out = main_dir_q;
  assign bus.valid_out     = main_valid_q;
  assign bad_dst_cnt       = bad_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rc_mesh_sub.sv
// ---------------------------------------------------------------------------
// tb_rc_mesh_sub : four router instances, (0,0) and (2,2) in XY and adaptive mode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rc_mesh_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] data_in;
  logic        valid_in;
  logic        rc_ready;
  logic [3:0]  pe, ps, pw, pn;

  logic [39:0] dout [4];
  logic [3:0]  dir  [4];
  logic        vout [4];
  logic        rdy  [4];
  logic [7:0]  bcnt [4];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] seq    = 32'h100;
  logic [43:0] exp_q [4][$];
  logic        tie_m [4];

  always #5 clk = ~clk;

  rc_mesh_sub_if #(.DATASIZE(40)) if0 ();
  rc_mesh_sub_if #(.DATASIZE(40)) if1 ();
  rc_mesh_sub_if #(.DATASIZE(40)) if2 ();
  rc_mesh_sub_if #(.DATASIZE(40)) if3 ();

  assign if0.data_in = data_in;  assign if0.valid_in = valid_in;  assign if0.rc_ready = rc_ready;
  assign if1.data_in = data_in;  assign if1.valid_in = valid_in;  assign if1.rc_ready = rc_ready;
  assign if2.data_in = data_in;  assign if2.valid_in = valid_in;  assign if2.rc_ready = rc_ready;
  assign if3.data_in = data_in;  assign if3.valid_in = valid_in;  assign if3.rc_ready = rc_ready;

  assign dout[0] = if0.data_out;  assign dir[0] = if0.direction_out;  assign vout[0] = if0.valid_out;  assign rdy[0] = if0.ready_out;
  assign dout[1] = if1.data_out;  assign dir[1] = if1.direction_out;  assign vout[1] = if1.valid_out;  assign rdy[1] = if1.ready_out;
  assign dout[2] = if2.data_out;  assign dir[2] = if2.direction_out;  assign vout[2] = if2.valid_out;  assign rdy[2] = if2.ready_out;
  assign dout[3] = if3.data_out;  assign dir[3] = if3.direction_out;  assign vout[3] = if3.valid_out;  assign rdy[3] = if3.ready_out;

  rc_mesh_sub #(.X_POS(0), .Y_POS(0), .ADAPTIVE(1)) u_a00 (
    .rc_clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .E_pressure_in(pe), .S_pressure_in(ps), .W_pressure_in(pw), .N_pressure_in(pn),
    .bad_dst_cnt(bcnt[0]));
  rc_mesh_sub #(.X_POS(0), .Y_POS(0), .ADAPTIVE(0)) u_x00 (
    .rc_clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .E_pressure_in(pe), .S_pressure_in(ps), .W_pressure_in(pw), .N_pressure_in(pn),
    .bad_dst_cnt(bcnt[1]));
  rc_mesh_sub #(.X_POS(2), .Y_POS(2), .ADAPTIVE(1)) u_a22 (
    .rc_clk(clk), .rst_n(rst_n), .bus(if2.slave),
    .E_pressure_in(pe), .S_pressure_in(ps), .W_pressure_in(pw), .N_pressure_in(pn),
    .bad_dst_cnt(bcnt[2]));
  rc_mesh_sub #(.X_POS(2), .Y_POS(2), .ADAPTIVE(0)) u_x22 (
    .rc_clk(clk), .rst_n(rst_n), .bus(if3.slave),
    .E_pressure_in(pe), .S_pressure_in(ps), .W_pressure_in(pw), .N_pressure_in(pn),
    .bad_dst_cnt(bcnt[3]));

  // Reference route: returns {tie_used, direction}.
  function automatic logic [4:0] model_route(input int xpos, input int ypos, input bit adapt,
                                             input logic [3:0] dst, input logic tie);
    logic [3:0] xp, yp, px, py;
    int dx, dy;
    dx = int'(dst[1:0]);
    dy = int'(dst[3:2]);
    xp = 4'b0000;  yp = 4'b0000;  px = 4'd0;  py = 4'd0;
    if (dx > xpos) begin xp = 4'b0010; px = pe; end
    else if (dx < xpos) begin xp = 4'b0100; px = pw; end
    if (dy > ypos) begin yp = 4'b0001; py = ps; end
    else if (dy < ypos) begin yp = 4'b1000; py = pn; end
    if (xp == 4'b0000 || yp == 4'b0000) return {1'b0, xp | yp};
    if (!adapt) return {1'b0, xp};
    if (px < py) return {1'b0, xp};
    if (py < px) return {1'b0, yp};
    return {1'b1, tie ? yp : xp};
  endfunction

  task automatic sb_monitor();
    logic [43:0] e;
    logic [4:0]  r;
    logic [3:0]  d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 4; k++) begin
          if (vout[k] && rc_ready) begin
            checks++;
            if (exp_q[k].size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected dut%0d: got %h/%b, expected no output", k, dout[k], dir[k]);
            end else begin
              e = exp_q[k].pop_front();
              if ({dout[k], dir[k]} !== e) begin
                errors++;
                $display("FAIL sb_flit dut%0d: got %h/%b, expected %h/%b", k, dout[k], dir[k], e[43:4], e[3:0]);
              end
            end
          end
          if (!vout[k]) begin
            checks++;
            if (dir[k] !== 4'hF) begin
              errors++;
              $display("FAIL idle_dir dut%0d: got %b, expected 1111", k, dir[k]);
            end
          end
          if (valid_in && rdy[k]) begin
            d = data_in[35:32];
            if (d[1:0] < 2'd3 && d[3:2] < 2'd3) begin
              r = model_route((k < 2) ? 0 : 2, (k < 2) ? 0 : 2, (k % 2) == 0, d, tie_m[k]);
              exp_q[k].push_back({data_in, r[3:0]});
              if (r[4]) tie_m[k] = !tie_m[k];
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    rc_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] dst);
    int n;
    n = 0;
    data_in  = {4'h0, dst, seq};
    seq      = seq + 32'd1;
    valid_in = 1'b1;
    @(negedge clk);
    while (!rdy[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_out stayed %b, expected 1 within 50 cycles", rdy[0]);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vout[k] !== 1'b0 || dir[k] !== 4'hF || dout[k] !== 40'd0 || bcnt[k] !== 8'd0 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s dut%0d: got v=%b dir=%b data=%h cnt=%0d rdy=%b, expected v=0 dir=1111 data=0 cnt=0 rdy=1",
                 tag, k, vout[k], dir[k], dout[k], bcnt[k], rdy[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;  valid_in = 1'b0;  rc_ready = 1'b1;  data_in = '0;
    pe = 4'd0;  ps = 4'd0;  pw = 4'd0;  pn = 4'd0;
    for (int k = 0; k < 4; k++) tie_m[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [3:0] dsts [3];
    logic [3:0] exps [3];
    dsts = '{4'b0000, 4'b0001, 4'b0100};
    exps = '{4'b0000, 4'b0010, 4'b0001};
    idle(2);
    for (int i = 0; i < 3; i++) begin
      send(dsts[i]);
      checks++;
      if (vout[0] !== 1'b1 || dir[0] !== exps[i]) begin
        errors++;
        $display("FAIL basic_route%0d: got v=%b dir=%b, expected v=1 dir=%b", i, vout[0], dir[0], exps[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (vout[0] !== 1'b0 || dir[0] !== 4'hF) begin
      errors++;
      $display("FAIL basic_idle: got v=%b dir=%b, expected v=0 dir=1111", vout[0], dir[0]);
    end
  endtask

  task automatic test_adaptive();
    logic [3:0] tie_exp [4];
    tie_exp = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
    idle(2);
    pe = 4'd3;  ps = 4'd1;
    send(4'b0101);
    checks++;
    if (dir[0] !== 4'b0001 || dir[1] !== 4'b0010) begin
      errors++;
      $display("FAIL adapt_e_busy: got a=%b x=%b, expected a=0001 x=0010", dir[0], dir[1]);
    end
    pe = 4'd1;  ps = 4'd3;
    send(4'b0101);
    checks++;
    if (dir[0] !== 4'b0010) begin
      errors++;
      $display("FAIL adapt_s_busy: got %b, expected 0010", dir[0]);
    end
    pe = 4'd2;  ps = 4'd2;
    for (int i = 0; i < 4; i++) begin
      send(4'b0101);
      checks++;
      if (dir[0] !== tie_exp[i] || dir[1] !== 4'b0010) begin
        errors++;
        $display("FAIL adapt_tie%0d: got a=%b x=%b, expected a=%b x=0010", i, dir[0], dir[1], tie_exp[i]);
      end
    end
  endtask

  task automatic test_corner();
    idle(2);
    pw = 4'd0;  pn = 4'd5;
    send(4'b0000);
    checks++;
    if (dir[2] !== 4'b0100 || dir[3] !== 4'b0100 || dir[0] !== 4'b0000) begin
      errors++;
      $display("FAIL corner22: got a22=%b x22=%b a00=%b, expected 0100 0100 0000", dir[2], dir[3], dir[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] a, b, c;
    idle(2);
    a = {4'h1, 4'b0001, seq};  b = {4'h2, 4'b0001, seq + 32'd1};  c = {4'h3, 4'b0001, seq + 32'd2};
    seq = seq + 32'd3;
    rc_ready = 1'b0;
    data_in = a;  valid_in = 1'b1;
    @(posedge clk);  #1;
    data_in = b;
    @(posedge clk);  #1;
    data_in = c;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0 || vout[0] !== 1'b1 || dout[0] !== a) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b data=%h, expected rdy=0 v=1 data=%h", rdy[0], vout[0], dout[0], a);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0 || dout[0] !== a || dir[0] !== 4'b0010) begin
      errors++;
      $display("FAIL bp_stable: got rdy=%b data=%h dir=%b, expected rdy=0 data=%h dir=0010", rdy[0], dout[0], dir[0], a);
    end
    @(posedge clk);  #1;
    rc_ready = 1'b1;
    @(posedge clk);  #1;
    checks++;
    if (vout[0] !== 1'b1 || dout[0] !== b) begin
      errors++;
      $display("FAIL bp_second: got v=%b data=%h, expected v=1 data=%h", vout[0], dout[0], b);
    end
    @(posedge clk);  #1;
    valid_in = 1'b0;
    checks++;
    if (vout[0] !== 1'b1 || dout[0] !== c) begin
      errors++;
      $display("FAIL bp_third: got v=%b data=%h, expected v=1 data=%h", vout[0], dout[0], c);
    end
  endtask

  task automatic test_bad_dst();
    idle(2);
    send(4'b0011);
    checks++;
    if (vout[0] !== 1'b0) begin
      errors++;
      $display("FAIL bad_x_forwarded: got v=%b, expected 0", vout[0]);
    end
    send(4'b1100);
    checks++;
    if (vout[0] !== 1'b0) begin
      errors++;
      $display("FAIL bad_y_forwarded: got v=%b, expected 0", vout[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bcnt[k] !== 8'd2) begin
        errors++;
        $display("FAIL bad_cnt2 dut%0d: got %0d, expected 2", k, bcnt[k]);
      end
    end
    repeat (300) send(4'b0011);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bcnt[k] !== 8'd255) begin
        errors++;
        $display("FAIL bad_cnt_sat dut%0d: got %0d, expected 255", k, bcnt[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(2);
    rc_ready = 1'b0;
    data_in  = {4'h4, 4'b0001, seq};
    seq      = seq + 32'd1;
    valid_in = 1'b1;
    @(posedge clk);  #1;
    @(posedge clk);  #1;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      tie_m[k] = 1'b0;
    end
    @(negedge clk);
    rst_n    = 1'b1;
    rc_ready = 1'b1;
    @(posedge clk);  #1;
    send(4'b0001);
    checks++;
    if (vout[0] !== 1'b1 || dir[0] !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_route: got v=%b dir=%b, expected v=1 dir=0010", vout[0], dir[0]);
    end
  endtask

  task automatic test_drain();
    idle(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL sb_leftover dut%0d: got %0d pending, expected 0", k, exp_q[k].size());
      end
    end
  endtask

  initial begin
    test_reset();
    fork
      sb_monitor();
    join_none
    test_basic();
    test_adaptive();
    test_corner();
    test_back_to_back();
    test_bad_dst();
    test_reset_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
